// File: rtl/fetch_unit.sv
// fetch_unit: single-stage instruction fetch feeding the D stage.
// It holds a fetch PC (PCF), a D-stage register set (InstrD/PCD/PC8D/ValidD),
// a one-entry skid buffer for a word that arrives while D is stalled, and
// redirect handling for branches and jumps resolved in D.
//
// Build option: define FETCH_DELAY_SLOT_EN to give redirects one architectural
// delay slot. The word at PCD+4 then still executes, and only later words are
// discarded. When the macro is undefined, every word younger than the
// redirecting instruction is discarded.
//
// Memory handshake: imem_req is held high with a stable imem_addr until
// imem_ack pulses for one cycle. imem_rdata is valid in that ack cycle only.
// An ack is honoured only while imem_req is high. At most one request is in
// flight at a time. A request can never be cancelled, so a redirected fetch
// waits for the outstanding ack, discards that word, and issues the target
// address on the following cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCControl,
  input  logic [15:0] ImmD,
  input  logic [25:0] IndexD,
  input  logic [31:0] RegJrD,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PC8D,
  output logic        ValidD,
  output logic        dbg_state
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  // State registers. The skid buffer is occupied exactly while in S_HOLD.
  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc8d_q, pc8d_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] tgt_q, tgt_d;
`ifdef FETCH_DELAY_SLOT_EN
  logic        ds_pend_q, ds_pend_d;
`endif

  logic        consume;
  logic        redirect;
  logic        ack_ok;
  logic        d_free;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;

  assign consume  = valid_q && !StallD;
  assign redirect = consume && (PCControl != 2'd0);
  assign ack_ok   = req_q && imem_ack;
  assign d_free   = !valid_q || consume;
  assign pc_plus4 = pcd_q + 32'd4;
  assign br_off   = {{14{ImmD[15]}}, ImmD, 2'b00};

  // Redirect target of the instruction in D. It is used only on a consume.
  always_comb begin
    target = pc_plus4;
    case (PCControl)
      2'd1:    target = pc_plus4 + br_off;
      2'd2:    target = RegJrD;
      2'd3:    target = {pc_plus4[31:28], IndexD, 2'b00};
      default: target = pc_plus4;
    endcase
  end

  // Next-state logic for the fetch FSM, the D stage, the buffer and the kill tracking.
  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    req_d       = req_q;
    instr_d     = instr_q;
    pcd_d       = pcd_q;
    pc8d_d      = pc8d_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    kill_d      = kill_q;
    tgt_d       = tgt_q;
`ifdef FETCH_DELAY_SLOT_EN
    ds_pend_d   = ds_pend_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          // First cycle out of reset: start fetching. D is empty here.
          req_d = 1'b1;
        end else if (kill_q) begin
          // A killed request is still outstanding. Drop its data and switch to the target.
          if (ack_ok) begin
            kill_d = 1'b0;
            pcf_d  = tgt_q;
          end
`ifdef FETCH_DELAY_SLOT_EN
        end else if (ds_pend_q) begin
          // The outstanding word is the delay slot. Keep it, then go to the target.
          if (ack_ok) begin
            instr_d   = imem_rdata;
            pcd_d     = pcf_q;
            pc8d_d    = pcf_q + 32'd8;
            valid_d   = 1'b1;
            pcf_d     = tgt_q;
            ds_pend_d = 1'b0;
          end
`endif
        end else if (ack_ok) begin
          if (d_free) begin
            if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
              instr_d = imem_rdata;
              pcd_d   = pcf_q;
              pc8d_d  = pcf_q + 32'd8;
              valid_d = 1'b1;
`else
              valid_d = 1'b0;
`endif
              pcf_d = target;
            end else begin
              instr_d = imem_rdata;
              pcd_d   = pcf_q;
              pc8d_d  = pcf_q + 32'd8;
              valid_d = 1'b1;
              pcf_d   = pcf_q + 32'd4;
            end
          end else begin
            // D is stalled. Park the word and stop requesting.
            buf_instr_d = imem_rdata;
            buf_pc_d    = pcf_q;
            pcf_d       = pcf_q + 32'd4;
            state_d     = S_HOLD;
            req_d       = 1'b0;
          end
        end else begin
          // The request is still in flight. A consume leaves a bubble in D.
          if (consume) begin
            valid_d = 1'b0;
          end
          if (redirect) begin
            tgt_d = target;
`ifdef FETCH_DELAY_SLOT_EN
            ds_pend_d = 1'b1;
`else
            kill_d = 1'b1;
`endif
          end
        end
      end
      S_HOLD: begin
        if (consume) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          if (redirect) begin
            pcf_d = target;
`ifdef FETCH_DELAY_SLOT_EN
            instr_d = buf_instr_q;
            pcd_d   = buf_pc_q;
            pc8d_d  = buf_pc_q + 32'd8;
            valid_d = 1'b1;
`else
            valid_d = 1'b0;
`endif
          end else begin
            instr_d = buf_instr_q;
            pcd_d   = buf_pc_q;
            pc8d_d  = buf_pc_q + 32'd8;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Register all state. Reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pcf_q       <= RESET_PC;
      req_q       <= 1'b0;
      instr_q     <= 32'd0;
      pcd_q       <= 32'd0;
      pc8d_q      <= 32'd0;
      valid_q     <= 1'b0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      kill_q      <= 1'b0;
      tgt_q       <= 32'd0;
`ifdef FETCH_DELAY_SLOT_EN
      ds_pend_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      req_q       <= req_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      pc8d_q      <= pc8d_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      kill_q      <= kill_d;
      tgt_q       <= tgt_d;
`ifdef FETCH_DELAY_SLOT_EN
      ds_pend_q   <= ds_pend_d;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PC8D      = pc8d_q;
  assign ValidD    = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle vectors for fetch_unit, plus a
// hand-written sequence that asserts reset in the middle of a request.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PCControl;
  logic [15:0] ImmD;
  logic [25:0] IndexD;
  logic [31:0] RegJrD;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PC8D;
  logic        ValidD;
  logic        dbg_state;

  int n_vec;
  int n_miss;

  typedef struct {
    logic        stall;
    logic        ack;
    logic [1:0]  pcc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pcd;
  } vec_t;

  vec_t vq[$];

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCControl  (PCControl),
    .ImmD       (ImmD),
    .IndexD     (IndexD),
    .RegJrD     (RegJrD),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PC8D       (PC8D),
    .ValidD     (ValidD),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: each word encodes its own address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic stall, input logic ack, input logic [1:0] pcc,
                     input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pcd);
    vec_t v;
    v.stall = stall; v.ack = ack; v.pcc = pcc; v.imm = imm; v.idx = idx; v.jr = jr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pcd = e_pcd;
    vq.push_back(v);
  endtask

  task automatic check_d(input string tag, input int i, input logic e_valid, input logic [31:0] e_pcd);
    chk({tag, "_valid"}, i, {31'd0, ValidD}, {31'd0, e_valid});
    if (e_valid) begin
      chk({tag, "_pcd"}, i, PCD, e_pcd);
      chk({tag, "_pc8d"}, i, PC8D, e_pcd + 32'd8);
      chk({tag, "_instr"}, i, InstrD, instr_of(e_pcd));
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    PCControl = 2'd0; ImmD = 16'd0; IndexD = 26'd0; RegJrD = 32'd0;
    StallD = 1'b0; imem_ack = 1'b0;

    // Each vector: inputs held for one cycle; expected outputs after that edge.
    // Sequential start with zero-wait memory
    add(0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3000, 0, 32'h0);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3004, 1, 32'h3000);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3008, 1, 32'h3004);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h300C, 1, 32'h3008);
    // beq at 3008 back to 3004, 300C acked the same cycle
`ifdef FETCH_DELAY_SLOT_EN
    add(0, 1, 1, 16'hFFFE, 26'h0, 32'h0, 1, 32'h3004, 1, 32'h300C);
`else
    add(0, 1, 1, 16'hFFFE, 26'h0, 32'h0, 1, 32'h3004, 0, 32'h0);
`endif
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3008, 1, 32'h3004);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h300C, 1, 32'h3008);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3010, 1, 32'h300C);
    // Stall for 3 cycles while 3010 is acked; no redirect sampled while stalled
    add(1, 1, 0, 16'h0, 26'h0, 32'h0, 0, 32'h0, 1, 32'h300C);
    add(1, 0, 2, 16'h0, 26'h0, 32'h1234_5678, 0, 32'h0, 1, 32'h300C);
    add(1, 0, 0, 16'h0, 26'h0, 32'h0, 0, 32'h0, 1, 32'h300C);
    add(0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3014, 1, 32'h3010);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3018, 1, 32'h3014);
    // Bubble: consume with the request still in flight
    add(0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3018, 0, 32'h0);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h301C, 1, 32'h3018);
    // jr to 3FF8 with 301C acked the same cycle
`ifdef FETCH_DELAY_SLOT_EN
    add(0, 1, 2, 16'h0, 26'h0, 32'h3FF8, 1, 32'h3FF8, 1, 32'h301C);
`else
    add(0, 1, 2, 16'h0, 26'h0, 32'h3FF8, 1, 32'h3FF8, 0, 32'h0);
`endif
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h3FFC, 1, 32'h3FF8);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4000, 1, 32'h3FFC);
    // j at 3FFC, IndexD=0001000 -> 4000
`ifdef FETCH_DELAY_SLOT_EN
    add(0, 1, 3, 16'h0, 26'h0001000, 32'h0, 1, 32'h4000, 1, 32'h4000);
`else
    add(0, 1, 3, 16'h0, 26'h0001000, 32'h0, 1, 32'h4000, 0, 32'h0);
`endif
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4004, 1, 32'h4000);
    add(0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4004, 0, 32'h0);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4008, 1, 32'h4004);
    // jr to 4000 while 4008 is outstanding; ack arrives 3 cycles late
    add(0, 0, 2, 16'h0, 26'h0, 32'h4000, 1, 32'h4008, 0, 32'h0);
    add(0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4008, 0, 32'h0);
    add(0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4008, 0, 32'h0);
`ifdef FETCH_DELAY_SLOT_EN
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4000, 1, 32'h4008);
`else
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4000, 0, 32'h0);
`endif
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4004, 1, 32'h4000);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h4008, 1, 32'h4004);
    // Buffer a word, then redirect out of HOLD (branch at 4004 -> 4048)
    add(1, 1, 0, 16'h0, 26'h0, 32'h0, 0, 32'h0, 1, 32'h4004);
`ifdef FETCH_DELAY_SLOT_EN
    add(0, 0, 1, 16'h0010, 26'h0, 32'h0, 1, 32'h4048, 1, 32'h4008);
`else
    add(0, 0, 1, 16'h0010, 26'h0, 32'h0, 1, 32'h4048, 0, 32'h0);
`endif
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h404C, 1, 32'h4048);
    // Wrap past FFFF_FFFC
`ifdef FETCH_DELAY_SLOT_EN
    add(0, 1, 2, 16'h0, 26'h0, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 1, 32'h404C);
`else
    add(0, 1, 2, 16'h0, 26'h0, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 0, 32'h0);
`endif
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
    add(0, 1, 0, 16'h0, 26'h0, 32'h0, 1, 32'h0000_0004, 1, 32'h0000_0000);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req", 0, {31'd0, imem_req}, 32'd0);
    chk("rst_addr", 0, imem_addr, 32'h3000);
    chk("rst_valid", 0, {31'd0, ValidD}, 32'd0);
    chk("rst_instr", 0, InstrD, 32'd0);
    chk("rst_pcd", 0, PCD, 32'd0);
    chk("rst_pc8d", 0, PC8D, 32'd0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < vq.size(); i++) begin
      StallD    = vq[i].stall;
      imem_ack  = vq[i].ack;
      PCControl = vq[i].pcc;
      ImmD      = vq[i].imm;
      IndexD    = vq[i].idx;
      RegJrD    = vq[i].jr;
      @(negedge clk);
      chk("v_req", i, {31'd0, imem_req}, {31'd0, vq[i].e_req});
      if (vq[i].e_req) chk("v_addr", i, imem_addr, vq[i].e_addr);
      check_d("v", i, vq[i].e_valid, vq[i].e_pcd);
    end

    // Reset asserted mid-request, late ack after release is ignored
    PCControl = 2'd0; StallD = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    chk("mid_req", 0, {31'd0, imem_req}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 0, {31'd0, ValidD}, 32'd0);
    chk("arst_req", 0, {31'd0, imem_req}, 32'd0);
    chk("arst_addr", 0, imem_addr, 32'h3000);
    @(negedge clk);
    rst_n = 1'b1;
    StallD = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    chk("late_req", 0, {31'd0, imem_req}, 32'd1);
    chk("late_addr", 0, imem_addr, 32'h3000);
    chk("late_valid", 0, {31'd0, ValidD}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("refetch_addr", 0, imem_addr, 32'h3004);
    check_d("refetch", 0, 1'b1, 32'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 PCControl  in  2  next-PC select from decode: 0 seq, 1 branch taken, 2 jr/jalr, 3 j/jal.
REQ-005 ImmD  in  16  branch offset of the instruction in D.
REQ-006 IndexD  in  26  jump index of the instruction in D.
REQ-007 RegJrD  in  32  forwarded register target for PCControl=2.
REQ-008 StallD  in  1  D stage holds; D instruction is not consumed.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  word-aligned fetch address.
REQ-011 imem_ack  in  1  one-cycle pulse; imem_rdata valid that cycle.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 InstrD / PCD / PC8D / ValidD  out  32/32/32/1  D-stage instruction, its PC, PC+8 (jal link), valid.

Function
REQ-014 "Consume" = ValidD && !StallD; PCControl, ImmD, IndexD and RegJrD are sampled only on consume.
REQ-015 Targets: 1 -> PCD+4+(sext(ImmD)<<2); 2 -> RegJrD; 3 -> {PCD+4[31:28],IndexD,2'b00}; all mod 2^32; no alignment check.
REQ-016 FSM states FETCH, HOLD. FETCH: imem_req=1, imem_addr=PCF; address and req stable until ack.
REQ-017 Ack in FETCH with D free (!ValidD or consume): next cycle InstrD=rdata, PCD=PCF, PC8D=PCF+8, ValidD=1, PCF=PCF+4; remain FETCH.
REQ-018 Ack in FETCH with D stalled: word captured in 1-entry buffer with its PC; go HOLD; imem_req=0.
REQ-019 HOLD -> FETCH on the cycle D is consumed; buffer moves to D next cycle.
REQ-020 Consume with no new word available: ValidD=0 next cycle (bubble).
REQ-021 Zero-wait memory (ack same cycle as req): one instruction per cycle sustained.
REQ-022 Redirect (consume with PCControl!=0): PCF loads target; every younger word (buffered, acked this cycle, or outstanding) is killed per REQ-031.
REQ-023 Killed outstanding request: imem_req stays high at old address until its ack; that ack's data is discarded; new address issued the following cycle.
REQ-024 A killed word never sets ValidD; ValidD=0 until the first target-path word arrives.
REQ-025 Redirect and ack in the same cycle: redirect wins; acked word follows REQ-031.
REQ-026 PCF, PCD, PC8D wrap modulo 2^32 past 32'hFFFF_FFFC.

Reset
REQ-027 rst_n low: PCF=RESET_PC, InstrD=0, PCD=0, PC8D=0, ValidD=0, imem_req=0, buffer empty, kill flag clear, state FETCH.
REQ-028 Reset is asynchronous to assertion; first imem_req rises in the first cycle after release.
REQ-029 Reset mid-transaction abandons the outstanding request; a late ack after release while no request is pending is ignored.
REQ-030 Outputs never X after reset regardless of imem_rdata.

Configuration
REQ-031 Macro FETCH_DELAY_SLOT_EN: defined -> word at PCD+4 (branch delay slot) is never killed and executes; only words at PCD+8 or later are killed; target loaded into PCF after the delay-slot request. Undefined -> all words younger than the redirecting instruction are killed (no delay slot).

Verification
REQ-032 Reset release, zero-wait memory, 4 sequential nops -> imem_addr 3000,3004,3008,300C on consecutive cycles; ValidD from cycle 2.
REQ-033 beq at PCD=3008, ImmD=16'hFFFE, PCControl=1 -> next fetch 3004; macro off: word 300C never valid; macro on: 300C valid, then 3004.
REQ-034 jr with RegJrD=32'h0000_4000 while fetch outstanding (ack 3 cycles late) -> stale data discarded, imem_addr=4000 cycle after the late ack.
REQ-035 StallD high 3 cycles during ack at 3010 -> HOLD, imem_req=0, InstrD unchanged; on release 3010 enters D, fetch 3014 issued.
REQ-036 j at PCD=3FFC, IndexD=26'h0001000 -> target 32'h0000_4000; PC8D=4004.
REQ-037 rst_n pulsed low mid-request -> ValidD=0 asynchronously; late ack ignored; refetch from 3000.
